// File: rtl/dual_fetch_unit_if.sv
// Per-channel fetch port bundle: program-memory read port, control inputs and
// the valid/ready instruction stream toward decode.
interface dual_fetch_unit_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [AW-1:0] pmem_o;
    logic [DW-1:0] pmem_data_i;
    logic          start_i;
    logic [AW-1:0] start_pc_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_pc_i;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [DW-1:0] instr_o;
    logic [AW-1:0] instr_pc_o;
    logic          busy_o;

    modport master (
        output pmem_o, instr_valid_o, instr_o, instr_pc_o, busy_o,
        input  pmem_data_i, start_i, start_pc_i, redirect_i, redirect_pc_i, instr_ready_i
    );
    modport slave (
        input  pmem_o, instr_valid_o, instr_o, instr_pc_o, busy_o,
        output pmem_data_i, start_i, start_pc_i, redirect_i, redirect_pc_i, instr_ready_i
    );
endinterface

// File: rtl/dual_fetch_unit.sv
// Two independent instruction fetch channels, each with its own PC, a 2-entry
// {instr, pc} queue and RET/redirect handling.
module dual_fetch_channel #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input logic              clk,
    input logic              reset,
    dual_fetch_unit_if.master ch
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          pc_q, pc_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [1:0][DW-1:0]     qi_q, qi_d;
    logic [1:0][AW-1:0]     qp_q, qp_d;
    logic                   flush, pop, enq, is_ret, wr_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            qi_q    <= '0;
            qp_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            qi_q    <= qi_d;
            qp_q    <= qp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        qi_d    = qi_q;
        qp_d    = qp_q;
        flush   = ch.redirect_i && (state_q != IDLE);
        pop     = !flush && (cnt_q != 2'd0) && ch.instr_ready_i;
        enq     = !flush && (state_q == FETCH) && ((cnt_q != 2'd2) || pop);
        is_ret  = (ch.pmem_data_i[DW-1 -: 4] == 4'hF);
        // Slot the new word lands in once any pop has shifted the queue.
        wr_idx  = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);

        if (flush) begin
            cnt_d   = 2'd0;
            pc_d    = ch.redirect_pc_i;
            state_d = FETCH;
        end else begin
            case (state_q)
                IDLE: if (ch.start_i) begin
                    pc_d    = ch.start_pc_i;
                    state_d = FETCH;
                end
                FETCH: if (enq) begin
                    if (is_ret) state_d = DRAIN;
                    else        pc_d    = pc_q + AW'(1);
                end
                DRAIN: if (pop && (cnt_q == 2'd1)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            // Shift only when a second entry exists, so the head stays stable when emptied.
            if (pop && (cnt_q == 2'd2)) begin
                qi_d[0] = qi_q[1];
                qp_d[0] = qp_q[1];
            end
            if (enq) begin
                qi_d[wr_idx] = ch.pmem_data_i;
                qp_d[wr_idx] = pc_q;
            end
            cnt_d = cnt_q + 2'(enq) - 2'(pop);
        end
    end

    assign ch.pmem_o        = pc_q;
    assign ch.instr_valid_o = (cnt_q != 2'd0);
    assign ch.instr_o       = qi_q[0];
    assign ch.instr_pc_o    = qp_q[0];
    assign ch.busy_o        = (state_q != IDLE);
endmodule

module dual_fetch_unit #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input logic              clk,
    input logic              reset,
    dual_fetch_unit_if.master ch1,
    dual_fetch_unit_if.master ch2
);
    dual_fetch_channel #(.AW(PROGRAM_MEM_ADDR_BITS), .DW(PROGRAM_MEM_DATA_BITS)) u_ch1 (
        .clk(clk), .reset(reset), .ch(ch1)
    );
    dual_fetch_channel #(.AW(PROGRAM_MEM_ADDR_BITS), .DW(PROGRAM_MEM_DATA_BITS)) u_ch2 (
        .clk(clk), .reset(reset), .ch(ch2)
    );
endmodule

// File: tb/tb_dual_fetch_unit.sv
// Self-checking bench for dual_fetch_unit: queue-based reference model compared
// every cycle, plus directed literal checks of the popped stream.
module tb_dual_fetch_unit;
    typedef logic [23:0] lq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];

    dual_fetch_unit_if #(.AW(8), .DW(16)) if1 ();
    dual_fetch_unit_if #(.AW(8), .DW(16)) if2 ();

    dual_fetch_unit #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16)) dut (
        .clk(clk), .reset(reset), .ch1(if1), .ch2(if2)
    );

    assign if1.pmem_data_i = mem1[if1.pmem_o];
    assign if2.pmem_data_i = mem2[if2.pmem_o];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state 0=idle 1=fetch 2=drain; queue entries are {instr, pc}.
    lq_t         mq1, mq2;
    int          mst1 = 0, mst2 = 0;
    logic [7:0]  mpc1 = '0, mpc2 = '0;

    task automatic mstep(inout lq_t q, inout int st, inout logic [7:0] pc,
                         input logic [15:0] w, input logic start, input logic [7:0] spc,
                         input logic redir, input logic [7:0] rpc, input logic rdy);
        bit popping;
        int st0;
        st0 = st;
        if (redir && st != 0) begin
            q.delete();
            pc = rpc;
            st = 1;
            return;
        end
        popping = (q.size() != 0) && rdy;
        if (popping) void'(q.pop_front());
        if (st0 == 0 && start) begin
            pc = spc;
            st = 1;
        end else if (st0 == 1 && q.size() < 2) begin
            q.push_back({w, pc});
            if (w[15:12] == 4'hF) st = 2;
            else pc = pc + 8'd1;
        end else if (st0 == 2 && popping && q.size() == 0) begin
            st = 0;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq1.delete(); mq2.delete();
            mst1 = 0; mst2 = 0; mpc1 = '0; mpc2 = '0;
        end else begin
            mstep(mq1, mst1, mpc1, mem1[mpc1], if1.start_i, if1.start_pc_i,
                  if1.redirect_i, if1.redirect_pc_i, if1.instr_ready_i);
            mstep(mq2, mst2, mpc2, mem2[mpc2], if2.start_i, if2.start_pc_i,
                  if2.redirect_i, if2.redirect_pc_i, if2.instr_ready_i);
        end
    end

    // Stream actually consumed by decode, for the literal checks.
    lq_t log1, log2;
    always @(posedge clk) begin
        if (!reset) begin
            if (if1.instr_valid_o && if1.instr_ready_i && !if1.redirect_i)
                log1.push_back({if1.instr_o, if1.instr_pc_o});
            if (if2.instr_valid_o && if2.instr_ready_i && !if2.redirect_i)
                log2.push_back({if2.instr_o, if2.instr_pc_o});
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("valid1", {31'd0, if1.instr_valid_o}, {31'd0, mq1.size() != 0});
            chk("busy1",  {31'd0, if1.busy_o}, {31'd0, mst1 != 0});
            chk("pmem1",  {24'd0, if1.pmem_o}, {24'd0, mpc1});
            if (mq1.size() != 0) begin
                chk("instr1",    {16'd0, if1.instr_o},    {16'd0, mq1[0][23:8]});
                chk("instr_pc1", {24'd0, if1.instr_pc_o}, {24'd0, mq1[0][7:0]});
            end
            chk("valid2", {31'd0, if2.instr_valid_o}, {31'd0, mq2.size() != 0});
            chk("busy2",  {31'd0, if2.busy_o}, {31'd0, mst2 != 0});
            chk("pmem2",  {24'd0, if2.pmem_o}, {24'd0, mpc2});
            if (mq2.size() != 0) begin
                chk("instr2",    {16'd0, if2.instr_o},    {16'd0, mq2[0][23:8]});
                chk("instr_pc2", {24'd0, if2.instr_pc_o}, {24'd0, mq2[0][7:0]});
            end
        end
    end

    task automatic chk_log(input string nm, input lq_t got, input lq_t exp);
        chk({nm, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), {8'd0, got[i]}, {8'd0, exp[i]});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        lq_t expq;
        bit  found;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0000;
            mem2[i] = 16'h0000;
        end
        mem1[8'h10] = 16'h1001; mem1[8'h11] = 16'h1002;
        mem1[8'h12] = 16'h1003; mem1[8'h13] = 16'hF000;
        mem1[8'h40] = 16'h2222; mem1[8'h41] = 16'hF000;
        mem2[8'hFE] = 16'h3001; mem2[8'hFF] = 16'h3002; mem2[8'h00] = 16'hF000;
        mem2[8'h80] = 16'h5001; mem2[8'h81] = 16'h5002;
        mem2[8'h82] = 16'h5003; mem2[8'h83] = 16'hF000;
        {if1.start_i, if1.redirect_i, if1.instr_ready_i} = '0;
        {if2.start_i, if2.redirect_i, if2.instr_ready_i} = '0;
        if1.start_pc_i = '0; if1.redirect_pc_i = '0;
        if2.start_pc_i = '0; if2.redirect_pc_i = '0;

        // Reset state
        cyc(2);
        chk("rst_pmem1",  {24'd0, if1.pmem_o}, 32'h0);
        chk("rst_valid1", {31'd0, if1.instr_valid_o}, 32'h0);
        chk("rst_busy1",  {31'd0, if1.busy_o}, 32'h0);
        chk("rst_instr1", {16'd0, if1.instr_o}, 32'h0);
        chk("rst_ipc2",   {24'd0, if2.instr_pc_o}, 32'h0);
        reset = 1'b0;
        cyc(1);

        // Sequential fetch
        if1.start_i = 1'b1; if1.start_pc_i = 8'h10; if1.instr_ready_i = 1'b1;
        cyc(1); if1.start_i = 1'b0;
        cyc(8);
        chk("seq_busy1", {31'd0, if1.busy_o}, 32'h0);
        chk("seq_pmem1", {24'd0, if1.pmem_o}, 32'h13);
        expq = '{24'h100110, 24'h100211, 24'h100312, 24'hF00013};
        chk_log("seq_log", log1, expq);

        // Backpressure
        log1.delete();
        if1.start_i = 1'b1; if1.instr_ready_i = 1'b0;
        cyc(1); if1.start_i = 1'b0;
        cyc(4);
        chk("bp_pmem1",  {24'd0, if1.pmem_o}, 32'h12);
        chk("bp_valid1", {31'd0, if1.instr_valid_o}, 32'h1);
        chk("bp_instr1", {16'd0, if1.instr_o}, 32'h1001);
        if1.instr_ready_i = 1'b1;
        cyc(8);
        chk_log("bp_log", log1, expq);

        // Redirect mid-stream while head is at 0x11
        log1.delete();
        if1.start_i = 1'b1;
        cyc(1); if1.start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(1);
            if (if1.instr_valid_o && if1.instr_pc_o == 8'h11) found = 1'b1;
        end
        chk("rd_found", {31'd0, found}, 32'h1);
        if1.redirect_i = 1'b1; if1.redirect_pc_i = 8'h40;
        cyc(1); if1.redirect_i = 1'b0;
        chk("rd_bubble", {31'd0, if1.instr_valid_o}, 32'h0);
        cyc(1);
        chk("rd_valid",  {31'd0, if1.instr_valid_o}, 32'h1);
        chk("rd_instr",  {16'd0, if1.instr_o}, 32'h2222);
        chk("rd_pc",     {24'd0, if1.instr_pc_o}, 32'h40);
        cyc(6);
        expq = '{24'h100110, 24'h222240, 24'hF00041};
        chk_log("rd_log", log1, expq);

        // Wrap-around on channel 2
        log2.delete();
        if2.start_i = 1'b1; if2.start_pc_i = 8'hFE; if2.instr_ready_i = 1'b1;
        cyc(1); if2.start_i = 1'b0;
        cyc(8);
        expq = '{24'h3001FE, 24'h3002FF, 24'hF00000};
        chk_log("wrap_log", log2, expq);
        chk("wrap_pmem2", {24'd0, if2.pmem_o}, 32'h0);
        chk("wrap_busy2", {31'd0, if2.busy_o}, 32'h0);

        // Channel independence
        log1.delete(); log2.delete();
        if1.start_i = 1'b1; if1.start_pc_i = 8'h10; if1.instr_ready_i = 1'b1;
        if2.start_i = 1'b1; if2.start_pc_i = 8'h80; if2.instr_ready_i = 1'b0;
        cyc(1); if1.start_i = 1'b0; if2.start_i = 1'b0;
        cyc(2);
        if1.redirect_i = 1'b1; if1.redirect_pc_i = 8'h40;
        cyc(1); if1.redirect_i = 1'b0;
        cyc(4);
        chk("ind_valid2", {31'd0, if2.instr_valid_o}, 32'h1);
        chk("ind_instr2", {16'd0, if2.instr_o}, 32'h5001);
        chk("ind_ipc2",   {24'd0, if2.instr_pc_o}, 32'h80);
        chk("ind_pmem2",  {24'd0, if2.pmem_o}, 32'h82);
        if2.instr_ready_i = 1'b1;
        cyc(8);
        expq = '{24'h500180, 24'h500281, 24'h500382, 24'hF00083};
        chk_log("ind_log2", log2, expq);
        expq = '{24'h100110, 24'h222240, 24'hF00041};
        chk_log("ind_log1", log1, expq);

        // Asynchronous reset while the channel 1 queue is full
        if1.start_i = 1'b1; if1.start_pc_i = 8'h10; if1.instr_ready_i = 1'b0;
        cyc(1); if1.start_i = 1'b0;
        cyc(3);
        chk("ar_pre_pmem1", {24'd0, if1.pmem_o}, 32'h12);
        #2;
        reset = 1'b1; if1.start_i = 1'b1;
        #1;
        chk("ar_valid1", {31'd0, if1.instr_valid_o}, 32'h0);
        chk("ar_busy1",  {31'd0, if1.busy_o}, 32'h0);
        chk("ar_pmem1",  {24'd0, if1.pmem_o}, 32'h0);
        cyc(2);
        reset = 1'b0; if1.start_i = 1'b0;
        cyc(3);
        chk("ar_post_busy1",  {31'd0, if1.busy_o}, 32'h0);
        chk("ar_post_valid1", {31'd0, if1.instr_valid_o}, 32'h0);
        chk("ar_post_pmem1",  {24'd0, if1.pmem_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/dual_fetch_unit.md
# dual_fetch_unit

Two-channel instruction fetcher that drives the two combinational read ports of the program memory. Each channel owns a program counter, fetches sequentially from a start PC, buffers fetched words in a 2-entry queue, and hands them to its core's decode stage over a valid/ready handshake. A channel stops fetching after RET and accepts branch redirects that flush its queue. It sits between the program memory and the two core pipelines' decode stages.

## Interface
- PROGRAM_MEM_ADDR_BITS, 8, instruction address width
- PROGRAM_MEM_DATA_BITS, 16, instruction width; opcode is bits [15:12]

Ports; suffix n is 1 or 2, and each channel has its own copy of every suffixed port.
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- pmemn  output  ADDR  program memory read address for channel n
- pmemn_data  input  DATA  combinational read data for pmemn, valid in the same cycle
- startn  input  1  begin fetching at start_pcn; sampled only in IDLE
- start_pcn  input  ADDR  first fetch address
- redirectn  input  1  branch taken: flush the queue and refetch from redirect_pcn
- redirect_pcn  input  ADDR  redirect target
- instr_validn  output  1  queue head is valid
- instr_readyn  input  1  decode accepts the head; pop when valid && ready
- instrn  output  DATA  queue head instruction
- instr_pcn  output  ADDR  address of the queue head instruction
- busyn  output  1  channel is in FETCH or DRAIN state

## Operation
- Both channels are fully independent and identical; there is no arbitration.
- Per-channel registers:
  - state: IDLE, FETCH, or DRAIN
  - fetch_pc
  - 2-entry queue of {instr, pc}, with count 0..2
- pmemn = fetch_pc, driven directly from the register.
- IDLE:
  - On startn: fetch_pc <= start_pcn, state <= FETCH.
  - redirectn is ignored.
- FETCH:
  - Enqueue when count < 2, or when count == 2 and a pop happens in the same cycle.
  - On enqueue, capture {pmemn_data, fetch_pc} and set fetch_pc <= fetch_pc + 1.
  - The increment is modulo 2^ADDR: 0xFF wraps to 0x00.
  - If the enqueued opcode is 4'hF (RET), state <= DRAIN and fetch_pc is not incremented.
- DRAIN:
  - Nothing is fetched.
  - When the queue becomes empty (count reaches 0 after a pop), state <= IDLE.
- Redirect (FETCH or DRAIN):
  - Queue is cleared (count <= 0), fetch_pc <= redirect_pcn, state <= FETCH.
  - No enqueue and no pop happen that cycle; redirect has priority over both.
- Queue is FIFO: pop presents the next entry. With simultaneous enqueue and pop, count is unchanged and order is preserved.
- instr_validn = (count != 0). instrn and instr_pcn show the head entry; their value is don't-care when invalid but held stable.
- startn asserted outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, fetch_pc 0, count 0, queue entries 0
  - pmemn 0, instr_validn 0, instrn 0, instr_pcn 0, busyn 0
- Start latency:
  - startn is sampled at edge E0.
  - During the following cycle, pmemn = start_pcn.
  - The word is captured at edge E1, and instr_validn is high after E1.
- Throughput: with instr_readyn held high, one instruction per cycle, and no bubble when the queue is full.
- Backpressure: with instr_readyn low, exactly 2 words are buffered and fetch_pc stalls at the address of the third word.
- Redirect latency:
  - redirectn is sampled at edge E0.
  - instr_validn is low after E0.
  - The redirect target word is valid after edge E1.
- busyn goes high the edge after startn is sampled, and goes low on the edge at which the RET entry is popped.
- An asynchronous reset mid-fetch forces all reset values immediately. Fetch resumes only on a new startn after reset deasserts.

## Test plan
- **Sequential fetch:** memory[0x10..0x13] = 0x1001, 0x1002, 0x1003, 0xF000; start_pc1 = 0x10; ready1 = 1.
  - Required: instr1 shows 0x1001, 0x1002, 0x1003, 0xF000 on consecutive cycles with instr_pc1 0x10..0x13.
  - Required: busy1 falls after the 0xF000 pop, and pmem1 holds at 0x13.
- **Backpressure:** same program with ready1 = 0 for 5 cycles, then 1.
  - Required: count saturates at 2 and pmem1 holds at 0x12 while stalled.
  - Required: after release, the stream order is unchanged, with no drop and no duplicate.
- **Redirect:** mid-stream at instr_pc 0x11, assert redirect1 with target 0x40; memory[0x40] = 0x2222.
  - Required: instr_valid1 is low for 1 cycle.
  - Required: the next valid is 0x2222 at pc 0x40; no 0x12 or 0x13 word ever appears.
- **Wrap-around:** start_pc2 = 0xFE, memory[0xFE] = 0x3001, memory[0xFF] = 0x3002, memory[0x00] = 0xF000.
  - Required: instr_pc2 sequence is 0xFE, 0xFF, 0x00.
- **Channel independence:**
  - Stimulus: start both channels on the same cycle with different programs; redirect channel 1 only; hold ready2 low.
  - Required: channel 2's queue and pmem2 are unaffected by channel 1's redirect.
- **Reset mid-operation:** assert reset asynchronously between edges while count = 2.
  - Required: instr_valid1, busy1 and pmem1 go to 0 before the next edge.
  - Required: startn arriving during reset has no effect.
